// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB destination info locally to drive forwarding selects, stalls, flushes and freezes.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_en,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_mr_q, ex_mr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_rw_q, mem_rw_d;
    logic                  mem_mr_q, mem_mr_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_rw_q, wb_rw_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic load_use;
    logic freeze;
    logic flush;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  exv,
        input logic                  mv,
        input logic                  mrw,
        input logic                  mmr,
        input logic [REG_ADDR_W-1:0] mrd,
        input logic                  wv,
        input logic                  wrw,
        input logic [REG_ADDR_W-1:0] wrd
    );
        if (!exv || rs == '0)                       return 2'b00;
        else if (mv && mrw && !mmr && mrd == rs)    return 2'b01;
        else if (wv && wrw && wrd == rs)            return 2'b10;
        else                                        return 2'b00;
    endfunction

    // rst_n gates freeze/flush so every output takes its reset value as soon as reset asserts
    assign freeze   = rst_n & !mem_ready;
    assign flush    = rst_n & ex_branch_taken;
    assign load_use = ex_valid_q & ex_mr_q & (ex_rd_q != '0) & id_valid &
                      ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        if (freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end

        fwd_a_sel = fwd_sel(ex_rs1_q, ex_valid_q, mem_valid_q, mem_rw_q, mem_mr_q, mem_rd_q,
                            wb_valid_q, wb_rw_q, wb_rd_q);
        fwd_b_sel = fwd_sel(ex_rs2_q, ex_valid_q, mem_valid_q, mem_rw_q, mem_mr_q, mem_rd_q,
                            wb_valid_q, wb_rw_q, wb_rd_q);
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_rw_d       = ex_rw_q;
        ex_mr_d       = ex_mr_q;
        mem_valid_d   = mem_valid_q;
        mem_rd_d      = mem_rd_q;
        mem_rw_d      = mem_rw_q;
        mem_mr_d      = mem_mr_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_rw_d       = wb_rw_q;
        stall_count_d = stall_count_q;
        if (pipe_en) begin
            ex_valid_d  = id_valid & !idex_bubble;
            ex_rs1_d    = id_rs1;
            ex_rs2_d    = id_rs2;
            ex_rd_d     = id_rd;
            ex_rw_d     = id_reg_write;
            ex_mr_d     = id_mem_read;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_rw_d    = ex_rw_q;
            mem_mr_d    = ex_mr_q;
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            wb_rw_d     = mem_rw_q;
        end
        if (!freeze && !flush && load_use && stall_count_q != '1)
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rw_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_rw_q      <= 1'b0;
            mem_mr_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_rw_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_rw_q       <= ex_rw_d;
            ex_mr_q       <= ex_mr_d;
            mem_valid_q   <= mem_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_rw_q      <= mem_rw_d;
            mem_mr_q      <= mem_mr_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_rw_q       <= wb_rw_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: directed instruction stream, hand-computed
// expected selects/controls queued per cycle and checked by an independent monitor.
module tb_hazard_forward_ctrl;

    localparam int RW = 5;
    localparam int CW = 32;

    // control modes for the expected-value table
    localparam int N = 0;  // normal
    localparam int L = 1;  // load-use stall
    localparam int F = 2;  // branch flush
    localparam int Z = 3;  // freeze

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          pc;
        logic          ifid;
        logic          fl;
        logic          bub;
        logic          pipe;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_read;
    logic          ex_branch_taken, mem_ready;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
    logic [CW-1:0] stall_count;

    exp_t exp_q[$];
    int   tag_q[$];
    int   n_cmp;
    int   n_err;

    hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_ready      (mem_ready),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .pipe_en        (pipe_en),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb, input int mode,
                                input int cnt);
        exp_t e;
        e.fa  = fa;
        e.fb  = fb;
        e.cnt = CW'(cnt);
        case (mode)
            L:       {e.pc, e.ifid, e.fl, e.bub, e.pipe} = 5'b00011;
            F:       {e.pc, e.ifid, e.fl, e.bub, e.pipe} = 5'b11111;
            Z:       {e.pc, e.ifid, e.fl, e.bub, e.pipe} = 5'b00000;
            default: {e.pc, e.ifid, e.fl, e.bub, e.pipe} = 5'b11001;
        endcase
        return e;
    endfunction

    // one cycle: drive ID-stage instruction plus branch/ready, queue this cycle's expectation
    task automatic cyc(input int tag, input logic v, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input logic [RW-1:0] rd, input logic rw,
                       input logic mr, input logic br, input logic rdy,
                       input logic [1:0] fa, input logic [1:0] fb, input int mode,
                       input int cnt);
        @(posedge clk);
        #1;
        id_valid        = v;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rd           = rd;
        id_reg_write    = rw;
        id_mem_read     = mr;
        ex_branch_taken = br;
        mem_ready       = rdy;
        exp_q.push_back(mk(fa, fb, mode, cnt));
        tag_q.push_back(tag);
    endtask

    // monitor: samples one queued expectation per falling clock edge or reset assertion
    initial begin
        exp_t e;
        exp_t a;
        int   t;
        n_cmp = 0;
        n_err = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en,
                     stall_count};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL step%0d: got fa=%b fb=%b pc=%b ifid=%b fl=%b bub=%b pipe=%b cnt=%0d, want fa=%b fb=%b pc=%b ifid=%b fl=%b bub=%b pipe=%b cnt=%0d",
                             t, a.fa, a.fb, a.pc, a.ifid, a.fl, a.bub, a.pipe, a.cnt,
                             e.fa, e.fb, e.pc, e.ifid, e.fl, e.bub, e.pipe, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rd           = '0;
        id_reg_write    = 1'b0;
        id_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_ready       = 1'b1;
        exp_q.push_back(mk(2'b00, 2'b00, N, 0));
        tag_q.push_back(0);
        #12;
        rst_n = 1'b1;

        //   tag v  rs1 rs2 rd  rw mr br rdy  fa     fb     mode cnt
        cyc(1,  1,  1,  2,  5,  1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // add x5
        cyc(2,  1,  5,  6,  8,  1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // sub x8,x5,x6
        cyc(3,  1,  9,  5,  10, 1, 0, 0, 1, 2'b01, 2'b00, N, 0);  // sub in EX: A from MEM
        cyc(4,  0,  0,  0,  0,  0, 0, 0, 1, 2'b00, 2'b10, N, 0);  // rs2=x5 from WB
        cyc(5,  1,  0,  0,  7,  1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // write x7
        cyc(6,  1,  0,  0,  7,  1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // write x7 again
        cyc(7,  1,  7,  7,  11, 1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // reader of x7
        cyc(8,  1,  3,  4,  0,  1, 0, 0, 1, 2'b01, 2'b01, N, 0);  // MEM wins over WB; ID writes x0
        cyc(9,  1,  0,  0,  12, 1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // reader of x0
        cyc(10, 0,  0,  0,  0,  0, 0, 0, 1, 2'b00, 2'b00, N, 0);  // x0 never forwards
        cyc(11, 1,  1,  0,  3,  1, 1, 0, 1, 2'b00, 2'b00, N, 0);  // lw x3
        cyc(12, 1,  3,  2,  13, 1, 0, 0, 1, 2'b00, 2'b00, L, 0);  // add uses x3: stall
        cyc(13, 1,  3,  2,  13, 1, 0, 0, 1, 2'b00, 2'b00, N, 1);  // add held in ID
        cyc(14, 0,  0,  0,  0,  0, 0, 0, 1, 2'b10, 2'b00, N, 1);  // add in EX, x3 from WB
        cyc(15, 1,  0,  0,  4,  1, 1, 0, 1, 2'b00, 2'b00, N, 1);  // lw x4
        cyc(16, 1,  4,  0,  14, 1, 0, 1, 1, 2'b00, 2'b00, F, 1);  // branch beats load-use
        cyc(17, 0,  0,  0,  0,  0, 0, 0, 1, 2'b00, 2'b00, N, 1);  // count unchanged
        cyc(18, 1,  0,  0,  9,  1, 0, 0, 1, 2'b00, 2'b00, N, 1);  // write x9
        cyc(19, 1,  9,  0,  6,  1, 1, 0, 1, 2'b00, 2'b00, N, 1);  // lw x6,(x9)
        cyc(20, 1,  6,  0,  15, 1, 0, 0, 0, 2'b01, 2'b00, Z, 1);  // freeze x3, load-use pending
        cyc(21, 1,  6,  0,  15, 1, 0, 0, 0, 2'b01, 2'b00, Z, 1);
        cyc(22, 1,  6,  0,  15, 1, 0, 0, 0, 2'b01, 2'b00, Z, 1);
        cyc(23, 1,  6,  0,  15, 1, 0, 0, 1, 2'b01, 2'b00, L, 1);  // shadow held, stall now
        cyc(24, 1,  6,  0,  15, 1, 0, 0, 1, 2'b00, 2'b00, N, 2);
        cyc(25, 0,  0,  0,  0,  0, 0, 0, 1, 2'b10, 2'b00, N, 2);  // x6 from WB
        cyc(26, 1,  0,  0,  5,  1, 0, 0, 1, 2'b00, 2'b00, N, 2);  // write x5
        cyc(27, 1,  5,  5,  16, 1, 0, 0, 1, 2'b00, 2'b00, N, 2);  // reader of x5
        cyc(28, 0,  0,  0,  0,  0, 0, 0, 1, 2'b01, 2'b01, N, 2);  // both from MEM

        // asynchronous reset with EX/MEM valid, checked before the next rising edge
        @(negedge clk);
        #2;
        exp_q.push_back(mk(2'b00, 2'b00, N, 0));
        tag_q.push_back(29);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(30, 0,  0,  0,  0,  0, 0, 0, 1, 2'b00, 2'b00, N, 0);
        cyc(31, 1,  5,  5,  17, 1, 0, 0, 1, 2'b00, 2'b00, N, 0);  // reader of x5 after reset
        cyc(32, 0,  0,  0,  0,  0, 0, 0, 1, 2'b00, 2'b00, N, 0);  // no stale forward

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
